// File: rtl/adc_channel_scanner_pkg.sv
// Shared constants, FSM encodings and channel-pick helper for the ADC channel scanner.
package adc_scan_pkg;

   localparam int ADC_MAX_CHANNELS = 8;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SELECT = 3'd1;
   localparam logic [2:0] ST_SETTLE = 3'd2;
   localparam logic [2:0] ST_ACCUM  = 3'd3;
   localparam logic [2:0] ST_REPORT = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } chan_pick_t;

   function automatic logic nch_ok(input int n);
      return (n >= 1) && (n <= ADC_MAX_CHANNELS);
   endfunction

   // Scanning downwards leaves the lowest set bit as the final winner.
   function automatic chan_pick_t pick_lowest(input logic [7:0] mask);
      chan_pick_t p;
      p.found = 1'b0;
      p.idx   = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (mask[i]) begin
            p.found = 1'b1;
            p.idx   = 3'(i);
         end else begin
            p = p;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/adc_channel_scanner_if.sv
// Control, sample and result bundle between the scan controller and the scanner.
interface adc_channel_scanner_if #(
   parameter int NCH      = 8,
   parameter int W        = 16,
   parameter int MAX_LOG2 = 12
);
   localparam int LOG2_W = $clog2(MAX_LOG2 + 1);

   logic                  start;
   logic                  abort;
   logic [NCH-1:0]        channelEnable;
   logic [LOG2_W-1:0]     samplesLog2;
   logic [NCH*W-1:0]      adcLogicalData;
   logic [NCH-1:0]        adcLogicalValid;

   logic                  busy;
   logic                  done;
   logic                  resultValid;
   logic [2:0]            resultChannel;
   logic [W+MAX_LOG2-1:0] resultSum;
   logic [W-1:0]          resultMin;
   logic [W-1:0]          resultMax;
   logic [MAX_LOG2:0]     resultCount;
   logic                  resultTimeout;

   modport master (
      output start, abort, channelEnable, samplesLog2, adcLogicalData, adcLogicalValid,
      input  busy, done, resultValid, resultChannel, resultSum, resultMin, resultMax,
             resultCount, resultTimeout
   );

   modport slave (
      input  start, abort, channelEnable, samplesLog2, adcLogicalData, adcLogicalValid,
      output busy, done, resultValid, resultChannel, resultSum, resultMin, resultMax,
             resultCount, resultTimeout
   );
endinterface

// File: rtl/adc_channel_scanner_accum.sv
// Sum/min/max/count engine; outputs are the next-state values so the final sample
// can be captured into the result registers on the same edge that accepts it.
module adc_stat_accumulator #(
   parameter int ADC_WIDTH = 16,
   parameter int MAX_LOG2  = 12
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 clr_i,
   input  logic                                 en_i,
   input  logic signed [ADC_WIDTH-1:0]          sample_i,
   output logic signed [ADC_WIDTH+MAX_LOG2-1:0] sum_o,
   output logic signed [ADC_WIDTH-1:0]          min_o,
   output logic signed [ADC_WIDTH-1:0]          max_o,
   output logic        [MAX_LOG2:0]             count_o
);
   localparam int SUM_W = ADC_WIDTH + MAX_LOG2;
   localparam logic signed [ADC_WIDTH-1:0] MIN_INIT = {1'b0, {(ADC_WIDTH-1){1'b1}}};
   localparam logic signed [ADC_WIDTH-1:0] MAX_INIT = {1'b1, {(ADC_WIDTH-1){1'b0}}};

   logic signed [SUM_W-1:0]     sum_q, sum_d;
   logic signed [ADC_WIDTH-1:0] min_q, min_d;
   logic signed [ADC_WIDTH-1:0] max_q, max_d;
   logic        [MAX_LOG2:0]    count_q, count_d;
   logic signed [SUM_W-1:0]     sample_ext_s;

   assign sample_ext_s = {{MAX_LOG2{sample_i[ADC_WIDTH-1]}}, sample_i};

   // Next-state statistics: clear wins over accumulate.
   always_comb begin
      sum_d   = sum_q;
      min_d   = min_q;
      max_d   = max_q;
      count_d = count_q;
      if (clr_i) begin
         sum_d   = '0;
         min_d   = MIN_INIT;
         max_d   = MAX_INIT;
         count_d = '0;
      end else if (en_i) begin
         sum_d   = sum_q + sample_ext_s;
         min_d   = (sample_i < min_q) ? sample_i : min_q;
         max_d   = (sample_i > max_q) ? sample_i : max_q;
         count_d = count_q + 1'b1;
      end else begin
         count_d = count_q;
      end
   end

   // Statistics state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q   <= '0;
         min_q   <= MIN_INIT;
         max_q   <= MAX_INIT;
         count_q <= '0;
      end else begin
         sum_q   <= sum_d;
         min_q   <= min_d;
         max_q   <= max_d;
         count_q <= count_d;
      end
   end

   assign sum_o   = sum_d;
   assign min_o   = min_d;
   assign max_o   = max_d;
   assign count_o = count_d;

endmodule

// File: rtl/adc_channel_scanner.sv
// Scans enabled logical ADC channels in ascending order through one shared
// statistics engine, with settling discard, per-sample timeout and abort.
module adc_channel_scanner
   import adc_scan_pkg::*;
#(
   parameter int ADC_NUM_CHANNELS = 8,
   parameter int ADC_WIDTH        = 16,
   parameter int MAX_LOG2         = 12,
   parameter int SETTLE_SAMPLES   = 4,
   parameter int TIMEOUT_CYCLES   = 4096
) (
   input  logic                 adcClk,
   input  logic                 adcReset,
   adc_channel_scanner_if.slave scan_if
);
   localparam int LOG2_W = $clog2(MAX_LOG2 + 1);
   localparam int SUM_W  = ADC_WIDTH + MAX_LOG2;
   localparam int CNT_W  = MAX_LOG2 + 1;
   localparam int SET_W  = $clog2(SETTLE_SAMPLES + 2);
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [ADC_NUM_CHANNELS-1:0] CH_ONE = ADC_NUM_CHANNELS'(1);

   if (!nch_ok(ADC_NUM_CHANNELS)) begin : g_nch_check
      $error("adc_channel_scanner: ADC_NUM_CHANNELS must be between 1 and 8");
   end

   logic [2:0]                  state_q, state_d;
   logic [ADC_NUM_CHANNELS-1:0] rem_q, rem_d;
   logic [LOG2_W-1:0]           log2_q, log2_d;
   logic [2:0]                  chan_q, chan_d;
   logic [SET_W-1:0]            settle_q, settle_d;
   logic [TMO_W-1:0]            tmo_q, tmo_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic                        rvalid_q, rvalid_d;
   logic                        timeout_flag_s;
   logic                        load_res_s;

   logic [2:0]                  res_chan_q;
   logic signed [SUM_W-1:0]     res_sum_q;
   logic signed [ADC_WIDTH-1:0] res_min_q, res_max_q;
   logic [CNT_W-1:0]            res_cnt_q;
   logic                        res_tmo_q;

   logic [7:0]                  valid_ext_s;
   logic [8*ADC_WIDTH-1:0]      data_ext_s;
   logic [ADC_WIDTH-1:0]        data_arr_s [8];
   logic signed [ADC_WIDTH-1:0] sample_s;
   logic                        strobe_s;
   chan_pick_t                  pick_s;
   logic [CNT_W-1:0]            target_s;

   logic                        acc_clr_s, acc_en_s;
   logic signed [SUM_W-1:0]     acc_sum_s;
   logic signed [ADC_WIDTH-1:0] acc_min_s, acc_max_s;
   logic [CNT_W-1:0]            acc_cnt_s;

   assign valid_ext_s = 8'(scan_if.adcLogicalValid);
   assign data_ext_s  = (8*ADC_WIDTH)'(scan_if.adcLogicalData);

   for (genvar g = 0; g < 8; g++) begin : g_data_split
      assign data_arr_s[g] = data_ext_s[g*ADC_WIDTH +: ADC_WIDTH];
   end

   assign sample_s  = data_arr_s[chan_q];
   assign strobe_s  = valid_ext_s[chan_q];
   assign pick_s    = pick_lowest(8'(rem_q));
   assign target_s  = CNT_W'(1) << log2_q;
   assign acc_clr_s = (state_q == ST_SELECT);
   assign acc_en_s  = (state_q == ST_ACCUM) && strobe_s;

   adc_stat_accumulator #(
      .ADC_WIDTH (ADC_WIDTH),
      .MAX_LOG2  (MAX_LOG2)
   ) u_stat (
      .clk      (adcClk),
      .rst      (adcReset),
      .clr_i    (acc_clr_s),
      .en_i     (acc_en_s),
      .sample_i (sample_s),
      .sum_o    (acc_sum_s),
      .min_o    (acc_min_s),
      .max_o    (acc_max_s),
      .count_o  (acc_cnt_s)
   );

   // Scan FSM next-state, channel selection and timeout counting.
   always_comb begin
      state_d        = state_q;
      rem_d          = rem_q;
      log2_d         = log2_q;
      chan_d         = chan_q;
      settle_d       = settle_q;
      tmo_d          = tmo_q;
      busy_d         = busy_q;
      done_d         = 1'b0;
      load_res_s     = 1'b0;
      timeout_flag_s = 1'b0;
      if (scan_if.abort) begin
         state_d = ST_IDLE;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (scan_if.start) begin
                  rem_d   = scan_if.channelEnable;
                  log2_d  = (scan_if.samplesLog2 > LOG2_W'(MAX_LOG2)) ?
                            LOG2_W'(MAX_LOG2) : scan_if.samplesLog2;
                  busy_d  = 1'b1;
                  state_d = ST_SELECT;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_SELECT: begin
               if (pick_s.found) begin
                  chan_d   = pick_s.idx;
                  rem_d    = rem_q & ~(CH_ONE << pick_s.idx);
                  settle_d = '0;
                  tmo_d    = '0;
                  state_d  = (SETTLE_SAMPLES == 0) ? ST_ACCUM : ST_SETTLE;
               end else begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end
            end
            ST_SETTLE: begin
               if (strobe_s) begin
                  tmo_d = '0;
                  if (settle_q == SET_W'(SETTLE_SAMPLES - 1)) begin
                     state_d = ST_ACCUM;
                  end else begin
                     settle_d = settle_q + SET_W'(1);
                  end
               end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                  load_res_s     = 1'b1;
                  timeout_flag_s = 1'b1;
                  state_d        = ST_REPORT;
               end else begin
                  tmo_d = tmo_q + TMO_W'(1);
               end
            end
            ST_ACCUM: begin
               if (strobe_s) begin
                  tmo_d = '0;
                  if (acc_cnt_s == target_s) begin
                     load_res_s = 1'b1;
                     state_d    = ST_REPORT;
                  end else begin
                     state_d = ST_ACCUM;
                  end
               end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                  load_res_s     = 1'b1;
                  timeout_flag_s = 1'b1;
                  state_d        = ST_REPORT;
               end else begin
                  tmo_d = tmo_q + TMO_W'(1);
               end
            end
            ST_REPORT: state_d = ST_SELECT;
            ST_DONE:   state_d = ST_IDLE;
            default: begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
      rvalid_d = load_res_s;
   end

   // FSM and control registers.
   always_ff @(posedge adcClk or posedge adcReset) begin
      if (adcReset) begin
         state_q  <= ST_IDLE;
         rem_q    <= '0;
         log2_q   <= '0;
         chan_q   <= '0;
         settle_q <= '0;
         tmo_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         log2_q   <= log2_d;
         chan_q   <= chan_d;
         settle_q <= settle_d;
         tmo_q    <= tmo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         rvalid_q <= rvalid_d;
      end
   end

   // Result registers hold until the next report; an empty channel reports min/max as 0.
   always_ff @(posedge adcClk or posedge adcReset) begin
      if (adcReset) begin
         res_chan_q <= '0;
         res_sum_q  <= '0;
         res_min_q  <= '0;
         res_max_q  <= '0;
         res_cnt_q  <= '0;
         res_tmo_q  <= 1'b0;
      end else if (load_res_s) begin
         res_chan_q <= chan_q;
         res_sum_q  <= acc_sum_s;
         res_min_q  <= (acc_cnt_s == '0) ? '0 : acc_min_s;
         res_max_q  <= (acc_cnt_s == '0) ? '0 : acc_max_s;
         res_cnt_q  <= acc_cnt_s;
         res_tmo_q  <= timeout_flag_s;
      end
   end

   assign scan_if.busy          = busy_q;
   assign scan_if.done          = done_q;
   assign scan_if.resultValid   = rvalid_q;
   assign scan_if.resultChannel = res_chan_q;
   assign scan_if.resultSum     = res_sum_q;
   assign scan_if.resultMin     = res_min_q;
   assign scan_if.resultMax     = res_max_q;
   assign scan_if.resultCount   = res_cnt_q;
   assign scan_if.resultTimeout = res_tmo_q;

endmodule

// File: tb/tb_adc_channel_scanner.sv
// Self-checking bench for adc_channel_scanner: scan table plus abort, reset and timeout sequences.
`timescale 1ns/1ps
module tb_adc_channel_scanner;
   localparam int NCH = 8;
   localparam int W   = 16;
   localparam int ML  = 12;
   localparam int TMO = 64;

   typedef struct {
      logic [7:0] mask;
      logic [3:0] log2;
      int         exp_results;
      int         exp_done_ofs;
   } vec_t;

   typedef struct {
      logic [2:0]         ch;
      logic signed [27:0] sum;
      logic signed [15:0] mn;
      logic signed [15:0] mx;
      logic [12:0]        cnt;
      logic               tmo;
      int                 cyc;
   } exp_t;

   logic adcClk = 1'b0;
   logic adcReset;

   adc_channel_scanner_if #(.NCH(NCH), .W(W), .MAX_LOG2(ML)) bus ();

   adc_channel_scanner #(
      .ADC_NUM_CHANNELS (NCH),
      .ADC_WIDTH        (W),
      .MAX_LOG2         (ML),
      .SETTLE_SAMPLES   (4),
      .TIMEOUT_CYCLES   (TMO)
   ) dut (
      .adcClk   (adcClk),
      .adcReset (adcReset),
      .scan_if  (bus)
   );

   always #5 adcClk = ~adcClk;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   busy_cnt = 0;
   int   done_cnt = 0;
   int   res_cnt = 0;
   int   last_done_cyc = 0;
   logic [7:0] gen_on = 8'hFF;
   int   ramp_v = -5;
   exp_t sb_q[$];
   exp_t mon_e;
   vec_t vt[8];

   always @(posedge adcClk) cyc <= cyc + 1;

   function automatic int chan_val(input int ch);
      case (ch)
         0: return 100;
         1: return 7;
         2: return -3;
         3: return 1234;
         4: return -32768;
         5: return 32767;
         6: return 0;
         default: return 0;
      endcase
   endfunction

   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_done(input int done0, input int limit, input string name);
      int k = 0;
      while (done_cnt == done0 && k < limit) begin
         @(posedge adcClk);
         k++;
      end
      if (done_cnt == done0) begin
         checks++;
         errors++;
         $display("FAIL %s: no done within %0d cycles", name, limit);
      end
      #1;
   endtask

   // Sample source: constant channels, ch7 ramps -5..+2, gated by gen_on.
   initial begin
      bus.adcLogicalValid = '0;
      bus.adcLogicalData  = '0;
      forever begin
         @(posedge adcClk);
         #2;
         for (int i = 0; i < NCH; i++) begin
            bus.adcLogicalValid[i] = gen_on[i];
            bus.adcLogicalData[i*W +: W] = (i == 7) ? W'(ramp_v) : W'(chan_val(i));
         end
         if (gen_on[7]) ramp_v = (ramp_v == 2) ? -5 : ramp_v + 1;
      end
   end

   // Output monitor and scoreboard comparison.
   initial begin
      forever begin
         @(negedge adcClk);
         if (bus.busy === 1'b1) busy_cnt++;
         if (bus.done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
         end
         if (bus.resultValid === 1'b1) begin
            res_cnt++;
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got channel %0d expected no result", bus.resultChannel);
            end else begin
               mon_e = sb_q.pop_front();
               check("res_channel", {61'd0, bus.resultChannel}, {61'd0, mon_e.ch});
               check("res_sum", $signed(bus.resultSum), mon_e.sum);
               check("res_min", $signed(bus.resultMin), mon_e.mn);
               check("res_max", $signed(bus.resultMax), mon_e.mx);
               check("res_count", {51'd0, bus.resultCount}, {51'd0, mon_e.cnt});
               check("res_timeout", {63'd0, bus.resultTimeout}, {63'd0, mon_e.tmo});
               check("res_cycle", cyc, mon_e.cyc);
            end
         end
      end
   end

   task automatic run_vec(input vec_t v, input string name);
      int s, eff, period, j, done0, res0;
      exp_t e;
      eff    = (v.log2 > 4'(ML)) ? ML : int'(v.log2);
      period = 6 + (1 << eff);
      @(posedge adcClk);
      #1;
      bus.channelEnable = v.mask;
      bus.samplesLog2   = v.log2;
      bus.start         = 1'b1;
      s        = cyc;
      busy_cnt = 0;
      done0    = done_cnt;
      res0     = res_cnt;
      j        = 0;
      for (int ch = 0; ch < NCH; ch++) begin
         if (v.mask[ch]) begin
            e.ch  = 3'(ch);
            e.cnt = 13'(1 << eff);
            e.tmo = 1'b0;
            e.cyc = s + (j + 1) * period;
            if (ch == 7) begin
               e.sum = 28'(-12 * (1 << (eff - 3)));
               e.mn  = -16'sd5;
               e.mx  = 16'sd2;
            end else begin
               e.sum = 28'(longint'(chan_val(ch)) * (longint'(1) << eff));
               e.mn  = 16'(chan_val(ch));
               e.mx  = 16'(chan_val(ch));
            end
            sb_q.push_back(e);
            j++;
         end
      end
      @(posedge adcClk);
      #1;
      bus.start = 1'b0;
      wait_done(done0, 6000, name);
      check({name, "_done_cycle"}, last_done_cyc - s, v.exp_done_ofs);
      check({name, "_done_pulses"}, done_cnt - done0, 1);
      check({name, "_busy_cycles"}, busy_cnt, v.exp_done_ofs - 1);
      check({name, "_results"}, res_cnt - res0, v.exp_results);
      check({name, "_pending"}, sb_q.size(), 0);
   endtask

   initial begin
      int s, done0, res0;
      exp_t e;

      vt[0] = '{8'h05, 4'd2,  2, 22};
      vt[1] = '{8'h00, 4'd2,  0, 2};
      vt[2] = '{8'h80, 4'd3,  1, 16};
      vt[3] = '{8'h3A, 4'd1,  4, 34};
      vt[4] = '{8'hC1, 4'd4,  3, 68};
      vt[5] = '{8'h10, 4'd15, 1, 4104};
      vt[6] = '{8'h7F, 4'd0,  7, 51};
      vt[7] = '{8'h09, 4'd2,  2, 22};

      adcReset          = 1'b1;
      bus.start         = 1'b0;
      bus.abort         = 1'b0;
      bus.channelEnable = '0;
      bus.samplesLog2   = '0;
      #12;
      check("rst_busy", {63'd0, bus.busy}, 64'sd0);
      check("rst_done", {63'd0, bus.done}, 64'sd0);
      check("rst_valid", {63'd0, bus.resultValid}, 64'sd0);
      check("rst_sum", $signed(bus.resultSum), 64'sd0);
      check("rst_min", $signed(bus.resultMin), 64'sd0);
      check("rst_max", $signed(bus.resultMax), 64'sd0);
      check("rst_count", {51'd0, bus.resultCount}, 64'sd0);
      check("rst_timeout", {63'd0, bus.resultTimeout}, 64'sd0);
      @(posedge adcClk);
      #1;
      adcReset = 1'b0;
      repeat (3) @(posedge adcClk);

      for (int i = 0; i < 7; i++) begin
         run_vec(vt[i], $sformatf("vec%0d", i));
      end

      // Abort mid-ACCUM on ch3.
      @(posedge adcClk);
      #1;
      bus.channelEnable = 8'h08;
      bus.samplesLog2   = 4'd4;
      bus.start         = 1'b1;
      done0 = done_cnt;
      res0  = res_cnt;
      @(posedge adcClk);
      #1;
      bus.start = 1'b0;
      repeat (9) @(posedge adcClk);
      #1;
      bus.abort = 1'b1;
      @(negedge adcClk);
      check("abort_busy_before", {63'd0, bus.busy}, 64'sd1);
      @(posedge adcClk);
      #1;
      bus.abort = 1'b0;
      @(negedge adcClk);
      check("abort_busy_after", {63'd0, bus.busy}, 64'sd0);
      repeat (40) @(posedge adcClk);
      check("abort_no_done", done_cnt - done0, 0);
      check("abort_no_result", res_cnt - res0, 0);

      // Abort beats a simultaneous start.
      @(posedge adcClk);
      #1;
      bus.channelEnable = 8'h01;
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(posedge adcClk);
      #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      @(negedge adcClk);
      check("abort_start_busy", {63'd0, bus.busy}, 64'sd0);
      repeat (4) @(posedge adcClk);
      run_vec(vt[7], "rescan");

      // Asynchronous reset in the middle of a scan.
      @(posedge adcClk);
      #1;
      bus.channelEnable = 8'h01;
      bus.samplesLog2   = 4'd2;
      bus.start         = 1'b1;
      @(posedge adcClk);
      #1;
      bus.start = 1'b0;
      repeat (2) @(posedge adcClk);
      #2;
      check("midrst_busy_before", {63'd0, bus.busy}, 64'sd1);
      adcReset = 1'b1;
      #1;
      check("midrst_busy", {63'd0, bus.busy}, 64'sd0);
      check("midrst_sum", $signed(bus.resultSum), 64'sd0);
      check("midrst_count", {51'd0, bus.resultCount}, 64'sd0);
      check("midrst_channel", {61'd0, bus.resultChannel}, 64'sd0);
      @(posedge adcClk);
      #1;
      adcReset = 1'b0;
      repeat (3) @(posedge adcClk);

      // ch1 stops after 3 accumulated samples.
      gen_on = 8'h00;
      @(posedge adcClk);
      #1;
      bus.channelEnable = 8'h02;
      bus.samplesLog2   = 4'd4;
      bus.start         = 1'b1;
      s        = cyc;
      gen_on   = 8'h02;
      done0    = done_cnt;
      busy_cnt = 0;
      e = '{3'd1, 28'sd21, 16'sd7, 16'sd7, 13'd3, 1'b1, s + 73};
      sb_q.push_back(e);
      @(posedge adcClk);
      #1;
      bus.start = 1'b0;
      repeat (8) @(posedge adcClk);
      #1;
      gen_on = 8'h00;
      wait_done(done0, 200, "tmo_accum");
      check("tmo_accum_done_cycle", last_done_cyc - s, 75);
      check("tmo_accum_pending", sb_q.size(), 0);

      // ch6 never strobes: timeout during settle with an empty result.
      @(posedge adcClk);
      #1;
      bus.channelEnable = 8'h40;
      bus.samplesLog2   = 4'd2;
      bus.start         = 1'b1;
      s     = cyc;
      done0 = done_cnt;
      e = '{3'd6, 28'sd0, 16'sd0, 16'sd0, 13'd0, 1'b1, s + 66};
      sb_q.push_back(e);
      @(posedge adcClk);
      #1;
      bus.start = 1'b0;
      wait_done(done0, 200, "tmo_settle");
      check("tmo_settle_done_cycle", last_done_cyc - s, 68);
      check("tmo_settle_pending", sb_q.size(), 0);

      repeat (3) @(posedge adcClk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got no finish expected finish before 2ms");
      $fatal(1, "watchdog expired");
   end

endmodule
